// File: rtl/probe_capture.sv
// Debug capture engine: records a probe bus into a circular buffer around a
// masked trigger, then streams the frozen window out over a valid/ready port.
module probe_capture #(
   parameter int DATA_W = 96,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] probe_in,
   input  logic              arm,
   input  logic              abort,
   input  logic [DATA_W-1:0] trig_mask,
   input  logic [DATA_W-1:0] trig_value,
   input  logic              trig_mode,
   input  logic [ADDR_W-1:0] pre_len,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic [2:0]        state_o,
   output logic [ADDR_W-1:0] trig_addr
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_READ = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   ONE_F   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_F = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   LAST_F  = (ADDR_W + 1)'(DEPTH - 1);

   state_t              state, state_n;
   logic [DATA_W-1:0]   mask_r, value_r;
   logic                mode_r;
   logic [ADDR_W-1:0]   pre_r;
   logic                match, match_d, fire, arm_ok, wr_en;
   logic [ADDR_W-1:0]   wr_ptr, cnt, rd_ptr, rd_start;
   logic [ADDR_W:0]     fetch_cnt;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   q_p1, skid_data_p2;
   logic                vld_p1, last_p1, skid_vld_p2, skid_last_p2;
   logic                pop, out_free, issue, skid_ld;
   logic [1:0]          occ;

   always_comb begin
      match    = ((probe_in ^ value_r) & mask_r) == '0;
      fire     = (state == S_WAIT) && match && (!mode_r || !match_d);
      arm_ok   = (state == S_IDLE) && arm && !abort;
      wr_en    = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
      pop      = rd_valid && rd_ready;
      out_free = !rd_valid || rd_ready;
      // Items held or in flight; at most two may exist so the skid never overflows.
      occ      = 2'(rd_valid) + 2'(skid_vld_p2) + 2'(vld_p1);
      issue    = (state == S_READ) && !abort && (fetch_cnt != DEPTH_F) &&
                 ((occ - 2'(pop)) < 2'd2);
      skid_ld  = (state == S_READ) && !abort && vld_p1 && (!out_free || skid_vld_p2);
      rd_start = (fire ? wr_ptr : trig_addr) - pre_r;

      state_n = state;
      case (state)
         S_IDLE:  if (arm) state_n = (pre_len == '0) ? S_WAIT : S_PRE;
         S_PRE:   if ((cnt + ONE_A) == pre_r) state_n = S_WAIT;
         S_WAIT:  if (fire) state_n = (pre_r == LAST_A) ? S_READ : S_POST;
         S_POST:  if (cnt == ONE_A) state_n = S_READ;
         S_READ:  if (pop && rd_last) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort) state_n = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         match_d      <= 1'b0;
         wr_ptr       <= '0;
         cnt          <= '0;
         trig_addr    <= '0;
         rd_ptr       <= '0;
         fetch_cnt    <= '0;
         vld_p1       <= 1'b0;
         last_p1      <= 1'b0;
         skid_vld_p2  <= 1'b0;
         skid_last_p2 <= 1'b0;
         rd_valid     <= 1'b0;
         rd_last      <= 1'b0;
         rd_data      <= '0;
      end else begin
         state   <= state_n;
         match_d <= arm_ok ? 1'b0 : match;

         if (arm_ok) begin
            wr_ptr <= '0;
            cnt    <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + ONE_A;
         end
         if (state == S_PRE)  cnt <= cnt + ONE_A;
         if (state == S_POST) cnt <= cnt - ONE_A;
         if (fire) begin
            trig_addr <= wr_ptr;
            cnt       <= LAST_A - pre_r;
         end

         if ((state_n == S_READ) && (state != S_READ)) begin
            rd_ptr    <= rd_start;
            fetch_cnt <= '0;
         end else if (issue) begin
            rd_ptr    <= rd_ptr + ONE_A;
            fetch_cnt <= fetch_cnt + ONE_F;
         end

         // p1: RAM read data; p2: skid slot; output register faces the consumer
         vld_p1  <= issue;
         last_p1 <= issue && (fetch_cnt == LAST_F);
         if ((state != S_READ) || abort) begin
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            skid_vld_p2 <= 1'b0;
         end else if (out_free) begin
            if (skid_vld_p2) begin
               rd_valid     <= 1'b1;
               rd_data      <= skid_data_p2;
               rd_last      <= skid_last_p2;
               skid_vld_p2  <= vld_p1;
               skid_last_p2 <= last_p1;
            end else if (vld_p1) begin
               rd_valid <= 1'b1;
               rd_data  <= q_p1;
               rd_last  <= last_p1;
            end else begin
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
            end
         end else if (vld_p1) begin
            skid_vld_p2  <= 1'b1;
            skid_last_p2 <= last_p1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (arm_ok) begin
         mask_r  <= trig_mask;
         value_r <= trig_value;
         mode_r  <= trig_mode;
         pre_r   <= pre_len;
      end
      if (wr_en)   mem[wr_ptr]  <= probe_in;
      if (issue)   q_p1         <= mem[rd_ptr];
      if (skid_ld) skid_data_p2 <= q_p1;
   end

   assign state_o = state;

endmodule

// File: tb/tb_probe_capture.sv
// Bench for probe_capture (DATA_W=8, DEPTH=16): expected readout windows are
// derived from the driven probe pattern and checked beat by beat from a queue.
module tb_probe_capture;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst, arm, abort, trig_mode, rd_ready;
   logic [DATA_W-1:0] probe_in, trig_mask, trig_value, rd_data;
   logic [ADDR_W-1:0] pre_len, trig_addr;
   logic              rd_valid, rd_last;
   logic [2:0]        state_o;

   int checks = 0;
   int errors = 0;
   logic [7:0] pat [80];
   logic [7:0] exp_q [$];
   logic [3:0] exp_trig;

   probe_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .probe_in(probe_in), .arm(arm), .abort(abort),
      .trig_mask(trig_mask), .trig_value(trig_value), .trig_mode(trig_mode),
      .pre_len(pre_len), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .rd_ready(rd_ready), .state_o(state_o), .trig_addr(trig_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, required finish before 500000");
      $fatal(1);
   end

   function automatic logic mt(input logic [7:0] d, input logic [7:0] m, input logic [7:0] v);
      return ((d ^ v) & m) == 8'h00;
   endfunction

   task automatic fill_counter(input int base);
      for (int k = 0; k < 80; k++) pat[k] = 8'(base + k);
   endtask

   // Expected window: pre samples before the trigger cycle plus the rest of DEPTH after it.
   task automatic build_expected(input logic [7:0] m, input logic [7:0] v, input logic mode,
                                 input int pre);
      int   t;
      logic prev;
      t = -1;
      for (int k = pre + 1; k < 64 && t < 0; k++) begin
         prev = (k == 1) ? 1'b0 : mt(pat[k-1], m, v);
         if (mt(pat[k], m, v) && (!mode || !prev)) t = k;
      end
      if (t < 0) t = pre + 1;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(pat[t - pre + i]);
      exp_trig = 4'((t - 1) % DEPTH);
   endtask

   task automatic run_capture(input logic [7:0] m, input logic [7:0] v, input logic mode,
                              input int pre, input int rearm_k);
      bit ok;
      build_expected(m, v, mode, pre);
      @(posedge clk); #1;
      arm = 1'b1; trig_mask = m; trig_value = v; trig_mode = mode;
      pre_len = 4'(pre); probe_in = pat[0];
      ok = 1'b0;
      for (int k = 1; k < 80; k++) begin
         @(posedge clk); #1;
         arm        = (k == rearm_k);
         trig_mask  = ~m ^ 8'h5A;
         trig_value = ~v;
         trig_mode  = ~mode;
         pre_len    = 4'(15 - pre);
         if (state_o == 3'd4) begin
            ok = 1'b1;
            break;
         end
         probe_in = pat[k];
      end
      arm = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL capture_reach_read: state %0d, required 4", state_o);
      end
      checks++;
      if (trig_addr !== exp_trig) begin
         errors++;
         $display("FAIL trig_addr: got %0d, required %0d", trig_addr, exp_trig);
      end
   endtask

   task automatic run_read(input int ready_mode, input int rst_beat);
      int   beats, first_valid, gaps;
      bit   done, hold_v;
      logic [7:0] hold_d, e;
      logic hold_l;
      beats = 0; first_valid = -1; gaps = 0; done = 1'b0; hold_v = 1'b0;
      hold_d = '0; hold_l = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (hold_v) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== hold_d || rd_last !== hold_l) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b d=%0h l=%0b, required v=1 d=%0h l=%0b",
                        rd_valid, rd_data, rd_last, hold_d, hold_l);
            end
         end
         if (rd_valid === 1'b1 && first_valid < 0) first_valid = cyc;
         if (first_valid >= 0 && rd_valid !== 1'b1 && beats < DEPTH) gaps++;
         rd_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (rd_valid === 1'b1 && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got data %0h, required no beat", rd_data);
            end else begin
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  errors++;
                  $display("FAIL beat%0d_data: got %0h, required %0h", beats, rd_data, e);
               end
               checks++;
               if (rd_last !== (exp_q.size() == 0)) begin
                  errors++;
                  $display("FAIL beat%0d_last: got %0b, required %0b", beats, rd_last,
                           exp_q.size() == 0);
               end
            end
            beats++;
            if (beats == rst_beat) rst = 1'b1;
            hold_v = 1'b0;
         end else begin
            hold_v = (rd_valid === 1'b1);
            hold_d = rd_data;
            hold_l = rd_last;
         end
         @(posedge clk); #1;
         if (rst) begin
            rst = 1'b0;
            done = 1'b1;
            checks++;
            if (state_o !== 3'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
                rd_data !== 8'h00 || trig_addr !== 4'd0) begin
               errors++;
               $display("FAIL rst_in_readout: got st=%0d v=%0b l=%0b d=%0h ta=%0d, required all 0",
                        state_o, rd_valid, rd_last, rd_data, trig_addr);
            end
         end else if (beats == DEPTH) begin
            done = 1'b1;
            checks++;
            if (state_o !== 3'd0 || rd_valid !== 1'b0) begin
               errors++;
               $display("FAIL after_last: got st=%0d v=%0b, required st=0 v=0", state_o, rd_valid);
            end
         end
      end
      rd_ready = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL read_done: got %0d beats, required %0d", beats, DEPTH);
      end
      if (rst_beat == 0) begin
         checks++;
         if (first_valid < 0 || first_valid > 2) begin
            errors++;
            $display("FAIL first_valid_latency: got %0d, required <= 2", first_valid);
         end
      end
      if (ready_mode == 0 && rst_beat == 0) begin
         checks++;
         if (gaps != 0) begin
            errors++;
            $display("FAIL throughput_gaps: got %0d, required 0", gaps);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0; probe_in = '0;
      trig_mask = '0; trig_value = '0; trig_mode = 1'b0; pre_len = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d, required 0", state_o); end
      checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
         errors++; $display("FAIL reset_valid_last: got %0b%0b, required 00", rd_valid, rd_last);
      end
      checks++;
      if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h, required 0", rd_data); end
      checks++;
      if (trig_addr !== 4'd0) begin errors++; $display("FAIL reset_trig_addr: got %0d, required 0", trig_addr); end
   endtask

   task automatic test_level();
      fill_counter(8'h10);
      run_capture(8'hFF, 8'h20, 1'b0, 4, 0);
      run_read(0, 0);
   endtask

   task automatic test_random_ready();
      fill_counter(8'h10);
      run_capture(8'hFF, 8'h20, 1'b0, 4, 0);
      run_read(1, 0);
   endtask

   task automatic test_edge();
      fill_counter(8'h60);
      for (int k = 0; k <= 6; k++) pat[k] = 8'h20;
      pat[7] = 8'h55; pat[8] = 8'h56; pat[9] = 8'h20;
      run_capture(8'hFF, 8'h20, 1'b1, 4, 0);
      run_read(0, 0);
   endtask

   task automatic test_pre_limits();
      fill_counter(8'h10);
      run_capture(8'hFF, 8'h20, 1'b0, 15, 0);
      run_read(0, 0);
      fill_counter(8'h10);
      run_capture(8'hFF, 8'h13, 1'b0, 0, 0);
      run_read(1, 0);
   endtask

   task automatic test_mask_zero_rearm();
      fill_counter(8'hA0);
      run_capture(8'h00, 8'h77, 1'b0, 4, 8);
      run_read(0, 0);
   endtask

   task automatic test_abort_wait();
      int n;
      fill_counter(8'h10);
      @(posedge clk); #1;
      arm = 1'b1; abort = 1'b1; trig_mask = 8'hFF; trig_value = 8'hEE; trig_mode = 1'b0;
      pre_len = 4'd4;
      @(posedge clk); #1;
      arm = 1'b0; abort = 1'b0;
      checks++;
      if (state_o !== 3'd0) begin
         errors++; $display("FAIL abort_beats_arm: got %0d, required 0", state_o);
      end
      arm = 1'b1;
      n = 0;
      for (int k = 1; k < 40 && n < 3; k++) begin
         @(posedge clk); #1;
         arm = 1'b0;
         probe_in = pat[k];
         if (state_o == 3'd2) n++;
      end
      checks++;
      if (n < 3) begin errors++; $display("FAIL reach_wait: got %0d wait cycles, required 3", n); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (state_o !== 3'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_wait: got st=%0d v=%0b, required st=0 v=0", state_o, rd_valid);
      end
      test_level();
   endtask

   task automatic test_rst_readout();
      fill_counter(8'h10);
      run_capture(8'hFF, 8'h20, 1'b0, 4, 0);
      run_read(0, 5);
      test_level();
   endtask

   initial begin
      test_reset();
      test_level();
      test_random_ready();
      test_edge();
      test_pre_limits();
      test_mask_zero_rearm();
      test_abort_wait();
      test_rst_readout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
